// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants and types for the M-stage data-memory access controller.
//   beop_e   : access-size encoding carried from decode (m_beop / w_beop)
//   state_e  : controller state encoding
//   meta_t   : per-access info forwarded to the W-stage load extender
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    BE_DEFAULT = 2'b00,
    BE_WORD    = 2'b01,
    BE_HALF    = 2'b10,
    BE_BYTE    = 2'b11
  } beop_e;

  localparam logic LOAD_EXT_SIGNED   = 1'b1;
  localparam logic LOAD_EXT_UNSIGNED = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0] addr_lo;
    beop_e      beop;
    logic       extop;
  } meta_t;

endpackage

// File: rtl/dmem_access_ctrl_store_align.sv
// Combinational store alignment for one data-memory access.
//   addr_lo    in  2   low byte-address bits
//   beop       in  2   access size (beop_e)
//   wdata      in  32  right-aligned store data
//   be         out 4   byte-lane enables
//   wdata_rep  out 32  store data replicated across the lanes
//   misaligned out 1   half on an odd address, or word off a word boundary
module dmem_access_ctrl_store_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  beop,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    be         = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (beop_e'(beop))
      BE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      BE_HALF: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      BE_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access controller.
// Converts a load/store in M into one word-aligned req/ack bus transaction,
// stalls the pipeline until it completes, and registers the raw read word
// plus byte-lane info across the M/W boundary. Misaligned accesses raise
// adel/ades instead of touching the bus; a hung bus is aborted after TIMEOUT
// BUSY cycles with a bus_err pulse.
//   m_*        M-stage request (valid, re, we, addr, wdata, beop, loadextop)
//   flush      kill the W result of the in-flight access
//   stall      freeze F/D/E/M
//   bus_*      req/ack memory bus (req, we, addr, be, wdata out; ack, rdata in)
//   w_*        M/W registers: valid pulse, raw word, addr_lo, beop, extop
//   adel/ades  misaligned load/store exception pulses
//   bus_err    timeout abort pulse
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_valid,
  input  logic        m_re,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [1:0]  m_beop,
  input  logic        m_loadextop,
  input  logic        flush,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        w_valid,
  output logic [31:0] w_dr,
  output logic [1:0]  w_addr_lo,
  output logic [1:0]  w_beop,
  output logic        w_loadextop,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             kill;
  meta_t            req_meta;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_misaligned;

  logic access;
  logic accept;
  logic trap;

  dmem_access_ctrl_store_align u_align (
    .addr_lo    (m_addr[1:0]),
    .beop       (m_beop),
    .wdata      (m_wdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .misaligned (al_misaligned)
  );

  assign access = m_valid & (m_re | m_we) & (m_beop != BE_DEFAULT);
  // A flush in IDLE suppresses both acceptance and the exception report.
  assign accept = (state == IDLE) & access & ~flush & ~al_misaligned;
  assign trap   = (state == IDLE) & access & ~flush &  al_misaligned;

  // Stall rises in the accept cycle and falls in the ack cycle so the
  // pipeline advances together with the W-stage valid pulse.
  assign stall   = accept | ((state == BUSY) & ~bus_ack);
  assign bus_req = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      kill        <= 1'b0;
      req_meta    <= '0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      w_valid     <= 1'b0;
      w_dr        <= '0;
      w_addr_lo   <= '0;
      w_beop      <= '0;
      w_loadextop <= 1'b0;
      adel        <= 1'b0;
      ades        <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      w_valid <= 1'b0;
      adel    <= 1'b0;
      ades    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= BUSY;
            cnt            <= '0;
            kill           <= 1'b0;
            bus_addr       <= {m_addr[31:2], 2'b00};
            bus_be         <= al_be;
            bus_wdata      <= al_wdata;
            bus_we         <= m_we;  // re&we together is a store
            req_meta.addr_lo <= m_addr[1:0];
            req_meta.beop    <= beop_e'(m_beop);
            req_meta.extop   <= m_loadextop;
          end else if (trap) begin
            adel <= ~m_we;
            ades <=  m_we;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (!bus_we) begin
              w_dr <= bus_rdata;
              // A flush landing in the ack cycle kills the result as well.
              if (!kill && !flush) begin
                w_valid     <= 1'b1;
                w_addr_lo   <= req_meta.addr_lo;
                w_beop      <= req_meta.beop;
                w_loadextop <= req_meta.extop;
              end
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= IDLE;
            kill    <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (flush) kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus a
// randomized sequence, checked against a transaction-level model.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, m_re, m_we, m_loadextop, flush;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_beop;
  logic        stall, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        w_valid, w_loadextop, adel, ades, bus_err;
  logic [31:0] w_dr;
  logic [1:0]  w_addr_lo, w_beop;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_valid(m_valid), .m_re(m_re), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_beop(m_beop), .m_loadextop(m_loadextop),
    .flush(flush), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .w_valid(w_valid), .w_dr(w_dr), .w_addr_lo(w_addr_lo),
    .w_beop(w_beop), .w_loadextop(w_loadextop),
    .adel(adel), .ades(ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the held M/W registers.
  logic [31:0] exp_dr;
  logic [1:0]  exp_lo, exp_op;
  logic        exp_ext;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_mis(input logic [1:0] op, input logic [1:0] lo);
    if (op == 2'd2) return (lo % 2) != 0;
    if (op == 2'd1) return lo != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      2'd3:    return 4'(1 << lo);
      2'd2:    return 4'(3 << (lo & 2'd2));
      2'd1:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'd3:    return (d & 32'hFF) * 32'h0101_0101;
      2'd2:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic check_w_regs(input string tag);
    check({tag, "_w_dr"}, w_dr, exp_dr);
    check({tag, "_w_lo"}, w_addr_lo, exp_lo);
    check({tag, "_w_op"}, w_beop, exp_op);
    check({tag, "_w_ext"}, w_loadextop, exp_ext);
  endtask

  // One access from the cycle it is presented; returns in the cycle where
  // its result pulse (w_valid / adel / ades / bus_err) is visible.
  // ack_delay = BUSY cycle index of bus_ack (>= TIMEOUT means never);
  // flush_at = BUSY cycle index carrying flush (-1 means none).
  task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] op,
                           input logic ext, input int ack_delay, input int flush_at,
                           input logic [31:0] rdata);
    logic store, mis, killed, timed_out;
    int   last;
    store  = we;
    mis    = exp_mis(op, addr[1:0]);
    killed = 1'b0;
    m_valid = 1'b1; m_re = re; m_we = we; m_addr = addr; m_wdata = wdata;
    m_beop = op; m_loadextop = ext; flush = 1'b0;
    #1;
    check("accept_stall", stall, !mis);
    tick();
    // Scramble the M inputs: the bus side must hold the latched request.
    m_valid = 1'b0; m_re = 1'b0; m_we = 1'b0;
    m_addr = $urandom; m_wdata = $urandom; m_beop = 2'($urandom);
    if (mis) begin
      check("adel", adel, !store);
      check("ades", ades, store);
      check("mis_w_valid", w_valid, 1'b0);
      check("mis_bus_req", bus_req, 1'b0);
      check("mis_stall", stall, 1'b0);
      return;
    end
    check("busy_pulses_quiet", {w_valid, adel, ades, bus_err}, 4'b0);
    last = (ack_delay < TIMEOUT) ? ack_delay : TIMEOUT - 1;
    for (int i = 0; i <= last; i++) begin
      bus_ack   = (i == ack_delay);
      flush     = (i == flush_at);
      bus_rdata = (i == ack_delay) ? rdata : $urandom;
      if (flush) killed = 1'b1;
      #1;
      check("busy_req", bus_req, 1'b1);
      check("busy_addr", bus_addr, {addr[31:2], 2'b00});
      check("busy_be", bus_be, exp_be(op, addr[1:0]));
      check("busy_wdata", bus_wdata, exp_wd(op, wdata));
      check("busy_we", bus_we, store);
      check("busy_stall", stall, i != ack_delay);
      tick();
    end
    bus_ack = 1'b0; flush = 1'b0;
    timed_out = (ack_delay >= TIMEOUT);
    if (!timed_out && !store) exp_dr = rdata;
    if (!timed_out && !store && !killed) begin
      exp_lo = addr[1:0]; exp_op = op; exp_ext = ext;
    end
    check("done_w_valid", w_valid, !timed_out && !store && !killed);
    check("done_bus_err", bus_err, timed_out);
    check("done_bus_req", bus_req, 1'b0);
    check("done_stall", stall, 1'b0);
    check_w_regs("done");
  endtask

  // A cycle presenting something that must not start an access.
  task automatic no_access(input int kind);
    m_valid = 1'b1; m_re = 1'b1; m_we = 1'($urandom); m_addr = $urandom;
    m_wdata = $urandom; m_beop = 2'($urandom_range(1, 3)); flush = 1'b0;
    case (kind)
      0: m_valid = 1'b0;
      1: m_beop = 2'b00;
      2: begin m_re = 1'b0; m_we = 1'b0; end
      default: flush = 1'b1;
    endcase
    #1;
    check("noacc_stall", stall, 1'b0);
    tick();
    m_valid = 1'b0; flush = 1'b0;
    check("noacc_bus_req", bus_req, 1'b0);
    check("noacc_pulses", {w_valid, adel, ades, bus_err}, 4'b0);
    check_w_regs("noacc");
  endtask

  initial begin
    rst_n = 1'b0;
    m_valid = 0; m_re = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_beop = 0;
    m_loadextop = 0; flush = 0; bus_ack = 0; bus_rdata = 0;
    exp_dr = 0; exp_lo = 0; exp_op = 0; exp_ext = 0;
    #3;
    check("rst_outs", {stall, bus_req, bus_we, bus_be, w_valid, adel, ades, bus_err}, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check_w_regs("rst");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // lw 0x1004, ack in third BUSY cycle -> stall high for three cycles.
    do_access(1, 0, 32'h0000_1004, 32'h0, 2'd1, LOAD_EXT_SIGNED, 2, -1, 32'hDEAD_BEEF);
    // sb at ...3, immediate ack.
    do_access(0, 1, 32'h0000_2003, 32'h0000_00A5, 2'd3, 1'b0, 0, -1, 32'h0);
    // lh at ...1 and sw at ...2: misaligned.
    do_access(1, 0, 32'h0000_3001, 32'h0, 2'd2, 1'b1, 0, -1, 32'h0);
    do_access(0, 1, 32'h0000_4002, 32'h1234_5678, 2'd1, 1'b0, 0, -1, 32'h0);
    // lbu at ...2, flush in second BUSY cycle, ack in third; back-to-back lw.
    do_access(1, 0, 32'h0000_5002, 32'h0, 2'd3, LOAD_EXT_UNSIGNED, 2, 1, 32'h1122_3344);
    do_access(1, 0, 32'h0000_6008, 32'h0, 2'd1, 1'b1, 0, -1, 32'hCAFE_F00D);
    // Hung bus: abort after TIMEOUT BUSY cycles.
    do_access(1, 0, 32'h0000_7000, 32'h0, 2'd1, 1'b0, 1000, -1, 32'h0);
    // Ack in the very cycle the timeout would fire: ack wins.
    do_access(1, 0, 32'h0000_8002, 32'h0, 2'd2, 1'b1, TIMEOUT - 1, -1, 32'h5555_AAAA);
    // re and we together is a store; also misaligned re+we reports ades.
    do_access(1, 1, 32'h0000_9002, 32'h0000_BEEF, 2'd2, 1'b0, 1, -1, 32'hFFFF_FFFF);
    do_access(1, 1, 32'h0000_9003, 32'h0000_BEEF, 2'd2, 1'b0, 1, -1, 32'hFFFF_FFFF);
    // Flush in the ack cycle kills the result.
    do_access(1, 0, 32'h0000_A001, 32'h0, 2'd3, 1'b1, 1, 1, 32'h7777_8888);
    for (int k = 0; k < 4; k++) no_access(k);

    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0) begin
        no_access($urandom_range(0, 3));
      end else begin
        sel = $urandom_range(0, 2);
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        do_access(sel != 1, sel != 0, a, $urandom, 2'($urandom_range(1, 3)),
                  1'($urandom), $urandom_range(0, 5),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                  $urandom);
      end
    end

    // Asynchronous reset in the middle of a BUSY wait.
    m_valid = 1; m_re = 1; m_we = 0; m_addr = 32'h0000_B00C; m_beop = 2'd1;
    m_loadextop = 1; flush = 0;
    tick();
    m_valid = 0;
    tick();
    check("pre_rst_busy", bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_req", bus_req, 1'b0);
    check("arst_outs", {stall, bus_we, bus_be, w_valid, adel, ades, bus_err}, 0);
    check("arst_bus_addr", bus_addr, 0);
    exp_dr = 0; exp_lo = 0; exp_op = 0; exp_ext = 0;
    check_w_regs("arst");
    #2 rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    tick();
    bus_ack = 1'b0;
    check("post_rst_no_completion", {w_valid, bus_req, stall}, 0);
    tick();
    check("post_rst_still_idle", {w_valid, bus_req, stall}, 0);
    check_w_regs("post_rst");
    do_access(1, 0, 32'h0000_C000, 32'h0, 2'd1, 1'b0, 0, -1, 32'h2468_ACE0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- M-stage data-memory access controller in the MIPS datapath.
- Turns load/store requests into a word-aligned req/ack bus transaction, and stalls the pipeline until the transaction completes.
- Registers the raw read word plus the byte-lane info into the M/W boundary; the W-stage load extender consumes these.
- Detects misaligned accesses and aborts hung transactions after a timeout.

Parameters:
- TIMEOUT, 64: maximum BUSY cycles without bus_ack before the access is aborted.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- m_valid  in  1  M-stage holds a live instruction.
- m_re  in  1  load.
- m_we  in  1  store.
- m_addr  in  32  byte address.
- m_wdata  in  32  store data, right-aligned.
- m_beop  in  2  access size: be_default, be_word, be_half, be_byte.
- m_loadextop  in  1  load_ext_signed / load_ext_unsigned.
- flush  in  1  kill the W result of the in-flight access.
- stall  out  1  freeze the F/D/E/M stages.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete.
- bus_rdata  in  32  read word, valid with bus_ack.
- w_valid  out  1  one-cycle pulse: W data valid.
- w_dr  out  32  raw read word.
- w_addr_lo  out  2  addr[1:0].
- w_beop  out  2  registered m_beop.
- w_loadextop  out  1  registered m_loadextop.
- adel  out  1  misaligned-load exception, one-cycle pulse.
- ades  out  1  misaligned-store exception, one-cycle pulse.
- bus_err  out  1  timeout abort, one-cycle pulse.

Behaviour:
- Reset: state=IDLE; every output register and w_* = 0; bus_* = 0; stall = 0; counter = 0.
- access = m_valid & (m_re | m_we) & m_beop != be_default.
- m_re and m_we both high: treated as a store.
- Misaligned conditions:
  - be_half with addr[0]=1.
  - be_word with addr[1:0]!=0.
- IDLE, access and misaligned:
  - no bus transaction.
  - next cycle: adel (load) or ades (store) pulses; w_valid stays 0.
  - remain IDLE; stall = 0.
- IDLE, access and aligned:
  - stall = 1 combinationally in the same cycle.
  - latch the request: word address, be, lane-replicated data, we, addr_lo, beop, extop.
  - go to BUSY; counter cleared.
- Byte enables and store data by size:
  - byte: bus_be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: bus_be = 0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - word: bus_be = 1111; wdata unchanged.
- BUSY:
  - bus_req = 1; address, be, wdata and we held stable until ack.
  - stall = !bus_ack, so stall drops in the ack cycle.
- BUSY, bus_ack:
  - go to IDLE.
  - next cycle: w_dr = bus_rdata for a load; w_dr unchanged for a store.
  - w_valid pulses 1 for loads only, unless a kill is pending.
  - Latency: ack in cycle k → w_valid in cycle k+1. Minimum total is 2 cycles (accept, then ack in the first BUSY cycle).
- BUSY, no ack: counter increments.
  - When counter == TIMEOUT-1 with no ack: go to IDLE, bus_req drops, bus_err pulses next cycle, w_valid = 0, stall released.
  - ack arriving in that same cycle wins; no bus_err.
- flush:
  - In IDLE: no access is accepted that cycle.
  - In BUSY: the bus transaction cannot be cancelled. Set the kill flag and keep waiting for ack; on completion w_valid = 0. The kill flag clears on entering IDLE.
- Back-to-back: after ack the state is IDLE, and the next M instruction can be accepted in the cycle after ack.
- Asynchronous reset mid-BUSY: bus_req drops immediately and no completion is reported.
- w_addr_lo, w_beop and w_loadextop update only when w_valid pulses; otherwise they hold.

Decomposition:
- header_ctrl.v holds the shared constants:
  - be_default=2'b00, be_word=2'b01, be_half=2'b10, be_byte=2'b11.
  - load_ext_signed=1'b1, load_ext_unsigned=1'b0.
  - FSM state encodings: IDLE=1'b0, BUSY=1'b1.
- One natural sub-module, store_align: combinational generation of byte enables, lane-replicated store data and the misaligned flag.

Test Plan:
- Aligned lw at 0x0000_1004, ack 3 cycles after req, rdata=0xDEADBEEF:
  - bus_addr=0x1004, bus_be=1111 for the whole wait.
  - stall high for 3 cycles.
  - w_valid pulses with w_dr=0xDEADBEEF, w_addr_lo=00.
- sb at 0x...0003, wdata=0x000000A5, ack immediate:
  - bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1.
  - no w_valid.
- lh at 0x...0001:
  - no bus_req, adel pulses one cycle, stall stays 0.
- sw at 0x...0002:
  - ades pulses; bus stays idle.
- lbu at 0x...0002 with flush asserted in the second BUSY cycle, ack in the third:
  - bus completes; w_valid stays 0; next load is accepted the cycle after ack.
- Load with no ack, TIMEOUT=64:
  - bus_req drops after 64 BUSY cycles; bus_err pulses once; stall released.
- Reset pulsed low mid-BUSY:
  - all outputs 0 asynchronously; state returns to IDLE.
